sram_chip_emulator: RTL
=======================

SRAM_CHIP_EMULATOR -- requirements
Module: sram_chip_emulator

Interface
REQ-001 Parameter ADDR_WIDTH, default 20, SHALL set the width of the chip address port (matches SRAM_CHIP_ADDRESS_WIDTH).
REQ-002 Parameter DEPTH_LOG2, default 12, SHALL set the number of stored words: 2^DEPTH_LOG2 words of 32 bits.
REQ-003 Parameter READ_LATENCY, default 1, legal 1..3, SHALL set the number of clock edges from sampled read request to data driven.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 ce_n  in  1  chip enable, active low.
REQ-007 oe_n  in  1  output enable, active low.
REQ-008 we_n  in  1  write enable, active low.
REQ-009 be_n  in  4  byte-lane enables, active low; bit i covers data[8i+7:8i].
REQ-010 address  in  ADDR_WIDTH  word address.
REQ-011 data  inout  32  shared data bus; driven only per REQ-020..022, otherwise high-Z.
REQ-012 init_busy  out  1  high while the power-on clear sweep runs.
REQ-013 contention_count  out  16  saturating count of cycles with oe_n=0 and we_n=0 under ce_n=0.
REQ-014 range_error  out  1  sticky; set when any accepted access has address bits above DEPTH_LOG2-1 nonzero.

Function
REQ-015 FSM states SHALL be CLEAR and READY; reset enters CLEAR with sweep index 0.
REQ-016 CLEAR SHALL write zero to one word per cycle, index 0 upward, and go to READY on the cycle after writing index 2^DEPTH_LOG2-1 (sweep = 2^DEPTH_LOG2 cycles); init_busy=1 exactly while in CLEAR.
REQ-017 In CLEAR, all chip accesses SHALL be ignored: no write, no drive, no counter or flag update.
REQ-018 Word index SHALL be address[DEPTH_LOG2-1:0]; upper bits SHALL alias and set range_error (REQ-014).
REQ-019 Write: in READY, a cycle with ce_n=0 and we_n=0 SHALL commit data bytes whose be_n bit is 0 into the indexed word at that edge; lanes with be_n=1 are unchanged; consecutive write cycles re-commit and are idempotent.
REQ-020 Read: in READY, a cycle with ce_n=0, oe_n=0, we_n=1 SHALL be a read request; the word is fetched at that edge and driven READ_LATENCY-1 cycles after the following edge, i.e. visible on data after READ_LATENCY rising edges.
REQ-021 During the drive cycle, lanes whose be_n bit was 0 at request time SHALL carry stored data; lanes with be_n=1 SHALL be high-Z.
REQ-022 Drive enable and data SHALL be pipelined per request; back-to-back requests to different addresses SHALL produce back-to-back driven words in order, one per cycle.
REQ-023 A read in the cycle immediately after a write to the same index SHALL return the newly written bytes (write-first).
REQ-024 ce_n=0, oe_n=0, we_n=0: write SHALL take priority, no read request is issued, contention_count SHALL increment, saturating at 16'hFFFF.
REQ-025 ce_n=1 SHALL suppress all reads, writes and counting regardless of oe_n/we_n.
REQ-026 A pending read in the pipeline SHALL still be driven even if a write to another index occurs meanwhile; if emulator would drive while we_n=0 that cycle, drive SHALL be suppressed for that cycle.

Reset
REQ-027 On rst=1 at an edge: state=CLEAR, sweep index=0, read pipeline and drive enables cleared (data high-Z next cycle), contention_count=0, range_error=0, init_busy=1.
REQ-028 Reset asserted mid-sweep or mid-read SHALL restart the sweep at index 0 and discard pending reads.
REQ-029 Stored memory contents are defined only after the sweep completes (all zero).

Verification
REQ-030 Reset, DEPTH_LOG2=4 -> init_busy high exactly 16 cycles, then 0; read of index 5 returns 32'h00000000.
REQ-031 Write 32'hDEADBEEF to addr 3 with be_n=4'b0000, then write 32'h11223344 to addr 3 with be_n=4'b1100, read addr 3 be_n=0 -> 32'hDEAD3344 after READ_LATENCY edges.
REQ-032 READ_LATENCY=2, reads of addr 1,2,3 on consecutive cycles (preloaded 1,2,3) -> data shows 1,2,3 on consecutive cycles starting 2 edges after first request, high-Z after.
REQ-033 ce_n=0, oe_n=0, we_n=0 held 3 cycles, data=32'hA5A5A5A5 -> word written, emulator never drives, contention_count=3; 70000 such cycles -> 16'hFFFF.
REQ-034 Access addr 20'h10003 with DEPTH_LOG2=12 -> aliases to index 3, range_error=1 and stays 1 until rst.
REQ-035 rst pulsed during sweep index 7 and during a pending read -> no drive on data, init_busy restarts full sweep from 0.

Source files
------------

// File: rtl/sram_chip_emulator.sv
// -----------------------------------------------------------------------------
// sram_chip_emulator
//
// Behavioural-but-synthesizable stand-in for an asynchronous-style SRAM chip,
// re-timed onto a single clock. After reset a clear sweep zeroes every word.
// The emulator then answers chip-style accesses. Writes commit at the sampling
// edge with byte-lane masking. Reads are fetched at the sampling edge and driven
// onto the shared bus after READ_LATENCY rising edges.
//
// Ports
//   clk              single clock, all state changes on its rising edge
//   rst              synchronous active-high reset
//   ce_n/oe_n/we_n   chip, output and write enables (active low)
//   be_n[3:0]        byte-lane enables (active low), bit i <-> data[8i+7:8i]
//   address          word address; only the low DEPTH_LOG2 bits select a word
//   data[31:0]       shared bidirectional data bus (high-Z unless driving)
//   init_busy        high while the clear sweep runs
//   contention_count saturating count of cycles with ce_n=oe_n=we_n=0
//   range_error      sticky flag: an accepted access had non-zero upper bits
// -----------------------------------------------------------------------------
module sram_chip_emulator #(
  parameter int ADDR_WIDTH   = 20,
  parameter int DEPTH_LOG2   = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_n,
  input  logic                  oe_n,
  input  logic                  we_n,
  input  logic [3:0]            be_n,
  input  logic [ADDR_WIDTH-1:0] address,
  inout  wire  [31:0]           data,
  output logic                  init_busy,
  output logic [15:0]           contention_count,
  output logic                  range_error
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                state_reg, state_next;
  logic [DEPTH_LOG2-1:0] sweep_idx_reg, sweep_idx_next;

  // Storage: plain array with a registered read port so it maps onto block RAM.
  logic [31:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  logic                  ready;
  logic                  wr_req;
  logic                  rd_req;
  logic                  contention;
  logic                  upper_nonzero;
  logic [DEPTH_LOG2-1:0] word_index;

  assign ready      = (state_reg == READY);
  assign word_index = address[DEPTH_LOG2-1:0];
  // Write wins when both enables are low, so a read is only a read with we_n=1.
  assign wr_req     = ready & ~ce_n & ~we_n;
  assign rd_req     = ready & ~ce_n & ~oe_n & we_n;
  assign contention = wr_req & ~oe_n;

  // Upper address bits alias onto the same words; they only feed the flag.
  generate
    if (ADDR_WIDTH > DEPTH_LOG2) begin : g_upper
      assign upper_nonzero = |address[ADDR_WIDTH-1:DEPTH_LOG2];
    end else begin : g_no_upper
      assign upper_nonzero = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control FSM: CLEAR sweeps one word per cycle, then READY forever.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= CLEAR;
      sweep_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sweep_idx_reg <= sweep_idx_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sweep_idx_next = sweep_idx_reg;
    case (state_reg)
      CLEAR: begin
        sweep_idx_next = sweep_idx_reg + 1'b1;
        if (sweep_idx_reg == {DEPTH_LOG2{1'b1}}) begin
          state_next = READY;
        end
      end
      READY: begin
        state_next = READY;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  assign init_busy = (state_reg == CLEAR);

  // ---------------------------------------------------------------------------
  // Single write port shared by the clear sweep and chip writes.
  // ---------------------------------------------------------------------------
  logic [3:0]            mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [31:0]           mem_wdata;

  always_comb begin
    mem_we    = 4'b0000;
    mem_waddr = word_index;
    mem_wdata = data;
    if (state_reg == CLEAR) begin
      mem_we    = 4'b1111;
      mem_waddr = sweep_idx_reg;
      mem_wdata = 32'h0000_0000;
    end else if (wr_req) begin
      mem_we    = ~be_n;
    end
  end

  always_ff @(posedge clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (mem_we[lane]) begin
        mem[mem_waddr][8*lane +: 8] <= mem_wdata[8*lane +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline. Stage 0 is the registered RAM read taken at the request
  // edge. A write can never share that edge with a read, so a read in the
  // cycle after a write to the same word naturally sees the new bytes.
  // The remaining READ_LATENCY-1 stages simply delay word, lane mask and valid.
  // ---------------------------------------------------------------------------
  logic [31:0]             word_pipe [READ_LATENCY];
  logic [3:0]              be_pipe   [READ_LATENCY];
  logic [READ_LATENCY-1:0] valid_pipe;

  always_ff @(posedge clk) begin
    word_pipe[0] <= mem[word_index];
    be_pipe[0]   <= be_n;
    if (rst) begin
      valid_pipe[0] <= 1'b0;
    end else begin
      valid_pipe[0] <= rd_req;
    end
  end

  generate
    for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        word_pipe[gi] <= word_pipe[gi-1];
        be_pipe[gi]   <= be_pipe[gi-1];
        if (rst) begin
          valid_pipe[gi] <= 1'b0;
        end else begin
          valid_pipe[gi] <= valid_pipe[gi-1];
        end
      end
    end
  endgenerate

  // A host that is writing owns the bus, so the output stage backs off for
  // that cycle; the read it was presenting is not retried.
  logic drive_en;
  assign drive_en = valid_pipe[READ_LATENCY-1] & we_n;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign data[8*gi +: 8] = (drive_en && !be_pipe[READ_LATENCY-1][gi])
                               ? word_pipe[READ_LATENCY-1][8*gi +: 8]
                               : 8'bzzzz_zzzz;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Status: contention counter and sticky range flag.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      contention_count <= 16'h0000;
      range_error      <= 1'b0;
    end else begin
      if (contention && (contention_count != 16'hFFFF)) begin
        contention_count <= contention_count + 16'h0001;
      end
      if ((wr_req || rd_req) && upper_nonzero) begin
        range_error <= 1'b1;
      end
    end
  end

endmodule
